// File: rtl/uart_rx_word_assembler_if.sv
// Word-assembler stream bundle: the byte stream coming in from the UART
// receiver and the valid/ready word stream going out to the CPU loader.
// The slave modport is the assembler's view; the master modport is the
// view of whoever drives bytes in and consumes words.
interface uart_rx_word_assembler_if #(
  parameter int BYTES_PER_WORD = 2
);
  logic [7:0]                  rx_data;
  logic                        rx_done;
  logic [8*BYTES_PER_WORD-1:0] word_data;
  logic                        word_valid;
  logic                        word_ready;

  modport slave (
    input  rx_data,
    input  rx_done,
    input  word_ready,
    output word_data,
    output word_valid
  );

  modport master (
    output rx_data,
    output rx_done,
    output word_ready,
    input  word_data,
    input  word_valid
  );
endinterface

// File: rtl/uart_rx_word_assembler.sv
// UART RX word assembler.
// Gathers BYTES_PER_WORD received bytes into one word, in MSB-first or
// LSB-first order, and queues finished words in a FIFO_DEPTH-entry FIFO.
// The CPU side takes words through a valid/ready handshake.
// Optional feature macro: RXWA_TIMEOUT_EN. When defined, a partial word
// that sees no new byte for TIMEOUT_CYCLES cycles is discarded and
// timeout_err pulses. When undefined, no timer exists and timeout_err is 0.
module uart_rx_word_assembler #(
  parameter int BYTES_PER_WORD = 2,
  parameter int MSB_FIRST      = 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clr,
  uart_rx_word_assembler_if.slave             bus,
  output logic                                overflow,
  output logic                                timeout_err,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0] byte_idx,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

  localparam int W    = 8 * BYTES_PER_WORD;
  localparam int IDXW = $clog2(BYTES_PER_WORD + 1);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(BYTES_PER_WORD - 1);
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE,
    COLLECT
  } state_t;

  state_t          state, state_next;
  logic [IDXW-1:0] idx_q, idx_next;
  logic [W-1:0]    partial_q, partial_next;
  logic [W-1:0]    held, assembled;
  logic [W-1:0]    mem [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0] count_q;
  logic            capture, last_byte, full, pop, push_req, push_ok;
  logic            tmo_hit;
  int              lane;

  // Handshake qualifiers: clr blocks both byte capture and FIFO pop, and a
  // push into a full FIFO only goes through if the head leaves this cycle.
  always_comb begin
    capture   = bus.rx_done && !clr;
    last_byte = (idx_q == LAST_IDX);
    full      = (count_q == FULL_COUNT);
    pop       = (count_q != '0) && bus.word_ready && !clr;
    push_req  = capture && last_byte;
    push_ok   = push_req && (!full || pop);
  end

  // Places the incoming byte in its lane and merges it with the bytes held
  // so far, so a completing byte can be pushed without a holding cycle.
  always_comb begin
    lane = 0;
    if (MSB_FIRST != 0) begin
      lane = BYTES_PER_WORD - 1 - int'(idx_q);
    end else begin
      lane = int'(idx_q);
    end
    held      = (state == IDLE) ? '0 : partial_q;
    assembled = held | (W'(bus.rx_data) << (8 * lane));
  end

`ifdef RXWA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q;

  assign tmo_hit = (state == COLLECT) && !bus.rx_done && !clr &&
                   (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Inter-byte timer: runs only while a partial word is held and restarts
  // on every received byte, so an arriving byte always beats expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_hit;
      if (state != COLLECT || bus.rx_done || clr || tmo_hit) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Assembler state register: current FSM state, byte count and held bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx_q     <= '0;
      partial_q <= '0;
    end else begin
      state     <= state_next;
      idx_q     <= idx_next;
      partial_q <= partial_next;
    end
  end

  // Next-state logic: clr wins, then a captured byte, then timeout. With a
  // single-byte word every capture completes, so the FSM never leaves IDLE.
  always_comb begin
    state_next   = state;
    idx_next     = idx_q;
    partial_next = partial_q;
    if (clr) begin
      state_next   = IDLE;
      idx_next     = '0;
      partial_next = '0;
    end else if (capture) begin
      if (last_byte) begin
        state_next   = IDLE;
        idx_next     = '0;
        partial_next = '0;
      end else begin
        state_next   = COLLECT;
        idx_next     = idx_q + 1'b1;
        partial_next = assembled;
      end
    end else if (tmo_hit) begin
      state_next   = IDLE;
      idx_next     = '0;
      partial_next = '0;
    end
  end

  // FIFO pointers, occupancy and the overflow pulse. Pushes and pops are
  // gated upstream, so the count never needs saturation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req && !push_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the head is masked while
  // the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= assembled;
    end
  end

  assign bus.word_valid = (count_q != '0);
  assign bus.word_data  = (count_q != '0) ? mem[rd_ptr] : '0;
  assign byte_idx       = idx_q;
  assign fifo_count     = count_q;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Directed bench for uart_rx_word_assembler. Three instances share one clock:
//   a: 2-byte MSB-first words, 4-deep FIFO, 10-cycle timeout
//   b: 4-byte LSB-first words
//   c: 1-byte words, 2-deep FIFO
// Timeout behaviour is exercised when RXWA_TIMEOUT_EN is defined; otherwise
// the bench checks that a partial word is held indefinitely.
module tb_uart_rx_word_assembler;

  logic clk = 1'b0;
  logic reset;
  logic clr_a, clr_b, clr_c;
  logic ovf_a, ovf_b, ovf_c;
  logic tmo_a, tmo_b, tmo_c;
  logic [1:0] idx_a;
  logic [2:0] idx_b;
  logic [0:0] idx_c;
  logic [2:0] cnt_a;
  logic [2:0] cnt_b;
  logic [1:0] cnt_c;

  int vectors    = 0;
  int miscompares = 0;
  int ovf_seen;
  int tmo_seen;

  uart_rx_word_assembler_if #(.BYTES_PER_WORD(2)) bus_a ();
  uart_rx_word_assembler_if #(.BYTES_PER_WORD(4)) bus_b ();
  uart_rx_word_assembler_if #(.BYTES_PER_WORD(1)) bus_c ();

  uart_rx_word_assembler #(
    .BYTES_PER_WORD(2), .MSB_FIRST(1), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(10)
  ) dut_a (
    .clk(clk), .reset(reset), .clr(clr_a), .bus(bus_a),
    .overflow(ovf_a), .timeout_err(tmo_a), .byte_idx(idx_a), .fifo_count(cnt_a)
  );

  uart_rx_word_assembler #(
    .BYTES_PER_WORD(4), .MSB_FIRST(0), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(10)
  ) dut_b (
    .clk(clk), .reset(reset), .clr(clr_b), .bus(bus_b),
    .overflow(ovf_b), .timeout_err(tmo_b), .byte_idx(idx_b), .fifo_count(cnt_b)
  );

  uart_rx_word_assembler #(
    .BYTES_PER_WORD(1), .MSB_FIRST(1), .FIFO_DEPTH(2), .TIMEOUT_CYCLES(10)
  ) dut_c (
    .clk(clk), .reset(reset), .clr(clr_c), .bus(bus_c),
    .overflow(ovf_c), .timeout_err(tmo_c), .byte_idx(idx_c), .fifo_count(cnt_c)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of byte-stream input into the selected instance, lets
  // the edge happen, then drops rx_done again.
  task automatic applyStimulus(input int sel, input logic done, input logic [7:0] data);
    case (sel)
      0: begin bus_a.rx_done = done; bus_a.rx_data = data; end
      1: begin bus_b.rx_done = done; bus_b.rx_data = data; end
      default: begin bus_c.rx_done = done; bus_c.rx_data = data; end
    endcase
    tick();
    bus_a.rx_done = 1'b0;
    bus_b.rx_done = 1'b0;
    bus_c.rx_done = 1'b0;
  endtask

  function automatic logic [15:0] wordA(input int n);
    logic [7:0] hi, lo;
    hi = 8'h10 + 8'(n);
    lo = 8'hC0 + 8'(n);
    return {hi, lo};
  endfunction

  initial begin
    reset = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    bus_a.rx_done = 1'b0; bus_a.rx_data = 8'h00; bus_a.word_ready = 1'b0;
    bus_b.rx_done = 1'b0; bus_b.rx_data = 8'h00; bus_b.word_ready = 1'b0;
    bus_c.rx_done = 1'b0; bus_c.rx_data = 8'h00; bus_c.word_ready = 1'b0;

    repeat (2) tick();
    checkOutput("rst_valid", bus_a.word_valid, 0);
    checkOutput("rst_data", bus_a.word_data, 0);
    checkOutput("rst_ovf", ovf_a, 0);
    checkOutput("rst_tmo", tmo_a, 0);
    checkOutput("rst_idx", idx_a, 0);
    checkOutput("rst_cnt", cnt_a, 0);
    reset = 1'b1;
    tick();

    $display("[TB] basic 2-byte MSB-first word");
    bus_a.word_ready = 1'b1;
    applyStimulus(0, 1'b1, 8'h12);
    checkOutput("b2_idx1", idx_a, 1);
    checkOutput("b2_valid_early", bus_a.word_valid, 0);
    applyStimulus(0, 1'b1, 8'h34);
    checkOutput("b2_valid", bus_a.word_valid, 1);
    checkOutput("b2_data", bus_a.word_data, 16'h1234);
    checkOutput("b2_idx0", idx_a, 0);
    applyStimulus(0, 1'b0, 8'h00);
    checkOutput("b2_valid_gone", bus_a.word_valid, 0);
    checkOutput("b2_cnt", cnt_a, 0);

    $display("[TB] 4-byte LSB-first word");
    bus_b.word_ready = 1'b1;
    applyStimulus(1, 1'b1, 8'h11);
    checkOutput("b4_idx1", idx_b, 1);
    applyStimulus(1, 1'b1, 8'h22);
    checkOutput("b4_idx2", idx_b, 2);
    applyStimulus(1, 1'b1, 8'h33);
    checkOutput("b4_idx3", idx_b, 3);
    applyStimulus(1, 1'b1, 8'h44);
    checkOutput("b4_idx0", idx_b, 0);
    checkOutput("b4_data", bus_b.word_data, 32'h44332211);
    checkOutput("b4_valid", bus_b.word_valid, 1);
    applyStimulus(1, 1'b0, 8'h00);
    checkOutput("b4_cnt", cnt_b, 0);

    $display("[TB] FIFO fill with overflow");
    bus_a.word_ready = 1'b0;
    ovf_seen = 0;
    for (int n = 1; n <= 5; n++) begin
      logic [15:0] w;
      w = wordA(n);
      applyStimulus(0, 1'b1, w[15:8]);
      ovf_seen += int'(ovf_a);
      applyStimulus(0, 1'b1, w[7:0]);
      ovf_seen += int'(ovf_a);
    end
    checkOutput("ovf_pulse", ovf_a, 1);
    checkOutput("ovf_cnt", cnt_a, 4);
    applyStimulus(0, 1'b0, 8'h00);
    checkOutput("ovf_clear", ovf_a, 0);
    checkOutput("ovf_once", 64'(ovf_seen), 1);
    bus_a.word_ready = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      checkOutput($sformatf("drain1_w%0d", n), bus_a.word_data, wordA(n));
      applyStimulus(0, 1'b0, 8'h00);
    end
    checkOutput("drain1_empty", bus_a.word_valid, 0);

    $display("[TB] FIFO full with pop during push");
    bus_a.word_ready = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      logic [15:0] w;
      w = wordA(n);
      applyStimulus(0, 1'b1, w[15:8]);
      applyStimulus(0, 1'b1, w[7:0]);
    end
    begin
      logic [15:0] w5;
      w5 = wordA(5);
      applyStimulus(0, 1'b1, w5[15:8]);
      bus_a.word_ready = 1'b1;
      applyStimulus(0, 1'b1, w5[7:0]);
    end
    checkOutput("pp_no_ovf", ovf_a, 0);
    checkOutput("pp_cnt", cnt_a, 4);
    for (int n = 2; n <= 5; n++) begin
      checkOutput($sformatf("drain2_w%0d", n), bus_a.word_data, wordA(n));
      applyStimulus(0, 1'b0, 8'h00);
    end
    checkOutput("drain2_empty", bus_a.word_valid, 0);
    checkOutput("drain2_ovf", ovf_a, 0);

    $display("[TB] synchronous clear");
    bus_a.word_ready = 1'b0;
    applyStimulus(0, 1'b1, 8'h01);
    applyStimulus(0, 1'b1, 8'h02);
    applyStimulus(0, 1'b1, 8'h03);
    applyStimulus(0, 1'b1, 8'h04);
    applyStimulus(0, 1'b1, 8'h05);
    checkOutput("clr_pre_cnt", cnt_a, 2);
    checkOutput("clr_pre_idx", idx_a, 1);
    clr_a = 1'b1;
    bus_a.word_ready = 1'b1;
    applyStimulus(0, 1'b1, 8'h06);
    clr_a = 1'b0;
    bus_a.word_ready = 1'b0;
    checkOutput("clr_cnt", cnt_a, 0);
    checkOutput("clr_idx", idx_a, 0);
    checkOutput("clr_valid", bus_a.word_valid, 0);
    checkOutput("clr_data", bus_a.word_data, 0);
    checkOutput("clr_ovf", ovf_a, 0);

    $display("[TB] asynchronous reset mid-word");
    applyStimulus(0, 1'b1, 8'h03);
    applyStimulus(0, 1'b1, 8'h04);
    applyStimulus(0, 1'b1, 8'h07);
    checkOutput("ar_pre_cnt", cnt_a, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("ar_cnt", cnt_a, 0);
    checkOutput("ar_idx", idx_a, 0);
    checkOutput("ar_valid", bus_a.word_valid, 0);
    checkOutput("ar_data", bus_a.word_data, 0);
    reset = 1'b1;
    tick();

`ifdef RXWA_TIMEOUT_EN
    $display("[TB] inter-byte timeout");
    bus_a.word_ready = 1'b1;
    tmo_seen = 0;
    applyStimulus(0, 1'b1, 8'hAA);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1'b0, 8'h00);
      tmo_seen += int'(tmo_a);
    end
    checkOutput("tmo_not_early", 64'(tmo_seen), 0);
    checkOutput("tmo_idx_held", idx_a, 1);
    applyStimulus(0, 1'b0, 8'h00);
    checkOutput("tmo_pulse", tmo_a, 1);
    checkOutput("tmo_idx", idx_a, 0);
    applyStimulus(0, 1'b0, 8'h00);
    checkOutput("tmo_pulse_end", tmo_a, 0);
    applyStimulus(0, 1'b1, 8'h55);
    applyStimulus(0, 1'b1, 8'h66);
    checkOutput("tmo_next_word", bus_a.word_data, 16'h5566);
    applyStimulus(0, 1'b0, 8'h00);
    applyStimulus(0, 1'b1, 8'h77);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1'b0, 8'h00);
    end
    applyStimulus(0, 1'b1, 8'h88);
    checkOutput("exp_no_tmo", tmo_a, 0);
    checkOutput("exp_valid", bus_a.word_valid, 1);
    checkOutput("exp_data", bus_a.word_data, 16'h7788);
    applyStimulus(0, 1'b0, 8'h00);
    checkOutput("exp_no_tmo_late", tmo_a, 0);
`else
    $display("[TB] partial word held without timeout");
    bus_a.word_ready = 1'b1;
    tmo_seen = 0;
    applyStimulus(0, 1'b1, 8'h99);
    for (int i = 0; i < 60; i++) begin
      applyStimulus(0, 1'b0, 8'h00);
      tmo_seen += int'(tmo_a);
    end
    checkOutput("hold_no_tmo", 64'(tmo_seen), 0);
    checkOutput("hold_idx", idx_a, 1);
    applyStimulus(0, 1'b1, 8'h9A);
    checkOutput("hold_data", bus_a.word_data, 16'h999A);
    applyStimulus(0, 1'b0, 8'h00);
`endif

    $display("[TB] single-byte words");
    bus_c.word_ready = 1'b1;
    applyStimulus(2, 1'b1, 8'h5A);
    checkOutput("b1_valid", bus_c.word_valid, 1);
    checkOutput("b1_data", bus_c.word_data, 8'h5A);
    checkOutput("b1_idx", idx_c, 0);
    applyStimulus(2, 1'b0, 8'h00);
    checkOutput("b1_empty", bus_c.word_valid, 0);
    bus_c.word_ready = 1'b0;
    applyStimulus(2, 1'b1, 8'hA1);
    applyStimulus(2, 1'b1, 8'hA2);
    checkOutput("b1_no_ovf", ovf_c, 0);
    applyStimulus(2, 1'b1, 8'hA3);
    checkOutput("b1_ovf", ovf_c, 1);
    checkOutput("b1_cnt", cnt_c, 2);
    bus_c.word_ready = 1'b1;
    checkOutput("b1_head1", bus_c.word_data, 8'hA1);
    applyStimulus(2, 1'b0, 8'h00);
    checkOutput("b1_head2", bus_c.word_data, 8'hA2);
    applyStimulus(2, 1'b0, 8'h00);
    checkOutput("b1_drained", bus_c.word_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_word_assembler.md
# uart_rx_word_assembler

Parametrised successor to the two-byte UART-to-CPU filter. Collects bytes from the UART receiver (`rx_data` qualified by `rx_done`) into words of `BYTES_PER_WORD` bytes in configurable byte order. Completed words are buffered in a small FIFO. The FIFO presents words to the CPU side through a valid/ready handshake instead of a single-cycle pulse. Sits between the UART RX core and the CPU instruction/data loader.

## Interface
- `BYTES_PER_WORD`, 2, bytes per assembled word; legal 1..8.
- `MSB_FIRST`, 1, 1: first received byte is the most significant; 0: first byte is the least significant.
- `FIFO_DEPTH`, 4, word buffer depth; power of two, ≥2.
- `TIMEOUT_CYCLES`, 50000, inter-byte timeout in clk cycles; ≥2. Used only with `RXWA_TIMEOUT_EN`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear of assembler and FIFO; highest priority after reset.
- `rx_data`  in  8  received byte; valid only while `rx_done`=1.
- `rx_done`  in  1  one byte per cycle high.
- `word_data`  out  8*BYTES_PER_WORD  FIFO head word; forced 0 when `word_valid`=0.
- `word_valid`  out  1  FIFO non-empty.
- `word_ready`  in  1  consumer accepts head when high together with `word_valid`.
- `overflow`  out  1  one-cycle pulse: completed word dropped because FIFO full.
- `timeout_err`  out  1  one-cycle pulse: partial word discarded by timeout.
- `byte_idx`  out  $clog2(BYTES_PER_WORD+1)  bytes held in current partial word.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  words in FIFO.

## Operation
- Reset values: `word_data`=0, `word_valid`=0, `overflow`=0, `timeout_err`=0, `byte_idx`=0, `fifo_count`=0, FSM=IDLE.
- FSM states:
  - IDLE: no partial word, `byte_idx`=0.
  - COLLECT: 1..B-1 bytes held.
- Transitions:
  - IDLE→COLLECT on `rx_done` when B>1.
  - COLLECT→IDLE on capture of byte B-1, on timeout, or on `clr`.
  - With B=1, every `rx_done` completes a word; the FSM stays in IDLE.
- Byte placement: the k-th byte received (k=0..B-1) lands in bits [8j+7:8j].
  - j = B-1-k when `MSB_FIRST`=1.
  - j = k when `MSB_FIRST`=0.
- Completion: on the cycle the final byte is captured, the full word (held bytes plus current `rx_data`) is pushed into the FIFO. There is no extra holding cycle.
- Push when full: a push into a full FIFO is accepted only if a pop (`word_valid`&`word_ready`) occurs in the same cycle. Otherwise the word is dropped, `overflow` pulses, and the assembler still returns to IDLE.
- Pop: `word_valid`&`word_ready` removes the head. Simultaneous push and pop leaves `fifo_count` unchanged.
- `clr`: empties the FIFO, discards the partial word, and suppresses any push or pop in that cycle. No pulse outputs are generated.
- Arithmetic: FIFO pointers wrap modulo `FIFO_DEPTH`; `fifo_count` saturates at neither end because pushes and pops are gated.

## Timing
- Latency: final `rx_done` at edge t → `word_valid`=1 and word on `word_data` after edge t (1 cycle), when the FIFO was empty.
- `overflow` and `timeout_err` are registered, high for exactly one cycle after the triggering edge.
- `byte_idx` updates on the edge that captures each byte.
- Back-to-back `rx_done` on consecutive cycles is supported at full rate.
- Asynchronous reset mid-word or with a non-empty FIFO discards all content immediately.

## Configuration
- `RXWA_TIMEOUT_EN` defined:
  - An inter-byte counter restarts on every `rx_done` and on entry to COLLECT.
  - If it reaches `TIMEOUT_CYCLES` cycles in COLLECT without `rx_done`, the partial word is discarded, `timeout_err` pulses, and the FSM goes to IDLE.
  - If `rx_done` arrives in the expiry cycle, the byte wins: it is captured and the counter restarts.
- `RXWA_TIMEOUT_EN` undefined: no counter is built, `timeout_err` is tied 0, and a partial word is held indefinitely until completed, `clr`, or reset.

## Test plan
- B=2, MSB_FIRST=1, `word_ready`=1: bytes 0x12, 0x34 → one cycle later `word_data`=0x1234, `word_valid` high 1 cycle, `fifo_count` returns to 0.
- B=4, MSB_FIRST=0: bytes 0x11, 0x22, 0x33, 0x44 → `word_data`=0x44332211; `byte_idx` steps 1,2,3,0.
- FIFO_DEPTH=4, `word_ready`=0, 5 words sent → `fifo_count`=4, `overflow` pulses once on the fifth word; drained order is words 1–4. Repeat with `word_ready`=1 during the fifth completion → no overflow.
- `RXWA_TIMEOUT_EN`, TIMEOUT_CYCLES=10, B=2: byte 0xAA, then idle 10 cycles → `timeout_err` pulse, `byte_idx`=0. Next bytes 0x55, 0x66 → 0x5566. Send `rx_done` exactly in the expiry cycle → byte captured, no `timeout_err`.
- `clr` asserted with 1 byte held and 2 words queued → next cycle `fifo_count`=0, `byte_idx`=0, `word_valid`=0, `word_data`=0. Assert `reset` low mid-word → same state immediately.
